daq_crc_frame_ctrl: RTL and testbench

- Sequences the existing 16-bit-data / CRC-32 generator (crc_gen) for one DAQ readout frame at a time.
- Accepts a stream of 16-bit payload words and forwards them downstream with 1-cycle latency.
- After the last payload word, appends the two CRC-32 words: most-significant half first, then least-significant half. Both halves are taken from the generator's registered crc output.
- Sits between the DAQ event builder and the optical/serial link word mux.

---
 rtl/daq_crc_frame_ctrl.sv | 136 +++++++++++++
 tb/tb_daq_crc_frame_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/daq_crc_frame_ctrl.sv
// Frame sequencer around the 16-bit CRC-32 generator: forwards payload words with
// one cycle of latency, then appends the CRC high and low halves.
module daq_crc_frame_ctrl #(
  parameter int MAX_WORDS = 4096,
  parameter int CNT_W     = 13
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [15:0]      din,
  input  logic             din_valid,
  input  logic             din_last,
  output logic             din_ready,
  output logic [15:0]      dout,
  output logic             dout_valid,
  output logic             dout_crc,
  output logic             frame_done,
  output logic             ovf,
  output logic [CNT_W-1:0] word_cnt,
  output logic             busy,
  output logic             crc_init,
  output logic             crc_calc,
  output logic             crc_dv,
  output logic [15:0]      crc_d,
  input  logic [15:0]      crc_word
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_INIT   = 3'd1,
    S_DATA   = 3'd2,
    S_CRC_HI = 3'd3,
    S_CRC_LO = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_WORDS - 1);

  state_t state_r, state_s;
  logic   accept_s;
  logic   at_limit_s;

  assign din_ready  = (state_r == S_DATA);
  assign accept_s   = din_ready & din_valid;
  assign at_limit_s = (word_cnt == LAST_CNT);
  assign busy       = (state_r != S_IDLE);
  assign crc_d      = din;

  // Next-state and generator control decode
  always_comb begin
    state_s  = state_r;
    crc_init = 1'b0;
    crc_calc = 1'b0;
    crc_dv   = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (start) state_s = S_INIT;
        else       state_s = S_IDLE;
      end
      S_INIT: begin
        crc_init = 1'b1;
        state_s  = S_DATA;
      end
      S_DATA: begin
        if (accept_s) begin
          crc_calc = 1'b1;
          crc_dv   = 1'b1;
          // reaching the word limit closes the frame even without din_last
          if (din_last || at_limit_s) state_s = S_CRC_HI;
          else                        state_s = S_DATA;
        end else begin
          state_s = S_DATA;
        end
      end
      S_CRC_HI: begin
        // dv without calc shifts the low CRC half onto crc_word
        crc_dv  = 1'b1;
        state_s = S_CRC_LO;
      end
      S_CRC_LO: begin
        state_s = S_IDLE;
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // State register and registered output datapath
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= S_IDLE;
      dout       <= 16'h0000;
      dout_valid <= 1'b0;
      dout_crc   <= 1'b0;
      frame_done <= 1'b0;
      ovf        <= 1'b0;
      word_cnt   <= '0;
    end else begin
      state_r    <= state_s;
      dout_valid <= 1'b0;
      dout_crc   <= 1'b0;
      frame_done <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (start) begin
            word_cnt <= '0;
            ovf      <= 1'b0;
          end
        end
        S_DATA: begin
          if (accept_s) begin
            dout       <= din;
            dout_valid <= 1'b1;
            word_cnt   <= word_cnt + CNT_W'(1);
            if (!din_last && at_limit_s) ovf <= 1'b1;
          end
        end
        S_CRC_HI: begin
          dout       <= crc_word;
          dout_valid <= 1'b1;
          dout_crc   <= 1'b1;
        end
        S_CRC_LO: begin
          dout       <= crc_word;
          dout_valid <= 1'b1;
          dout_crc   <= 1'b1;
          frame_done <= 1'b1;
        end
        default: begin
          dout_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_daq_crc_frame_ctrl.sv
// Bench for daq_crc_frame_ctrl with a behavioural CRC-32 generator and an output scoreboard.
module tb_daq_crc_frame_ctrl;

  localparam int MAXW = 8;
  localparam int CW   = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [15:0]   din;
  logic          din_valid;
  logic          din_last;
  logic          din_ready;
  logic [15:0]   dout;
  logic          dout_valid;
  logic          dout_crc;
  logic          frame_done;
  logic          ovf;
  logic [CW-1:0] word_cnt;
  logic          busy;
  logic          crc_init;
  logic          crc_calc;
  logic          crc_dv;
  logic [15:0]   crc_d;
  logic [15:0]   crc_word;

  daq_crc_frame_ctrl #(.MAX_WORDS(MAXW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .din(din), .din_valid(din_valid),
    .din_last(din_last), .din_ready(din_ready), .dout(dout), .dout_valid(dout_valid),
    .dout_crc(dout_crc), .frame_done(frame_done), .ovf(ovf), .word_cnt(word_cnt),
    .busy(busy), .crc_init(crc_init), .crc_calc(crc_calc), .crc_dv(crc_dv),
    .crc_d(crc_d), .crc_word(crc_word)
  );

  always #5 clk = ~clk;

  int checks_r = 0;
  int errors_r = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_r++;
    if (got !== exp) begin
      errors_r++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] step16(input logic [31:0] r_in, input logic [15:0] w);
    logic [31:0] r;
    r = r_in;
    for (int b = 0; b < 16; b++)
      r = (r >> 1) ^ (((r[0] ^ w[b]) == 1'b1) ? 32'hEDB88320 : 32'h0000_0000);
    return r;
  endfunction

  // Generator stand-in: reflected register, complemented on output
  logic [31:0] gen_r;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                gen_r <= 32'hFFFF_FFFF;
    else if (crc_init)        gen_r <= 32'hFFFF_FFFF;
    else if (crc_dv && crc_calc) gen_r <= step16(gen_r, crc_d);
    else if (crc_dv)          gen_r <= {gen_r[15:0], 16'h0000};
  end
  assign crc_word = ~gen_r[31:16];

  function automatic logic [31:0] crc_sw(input logic [15:0] ws[$]);
    logic [31:0] r;
    r = 32'hFFFF_FFFF;
    foreach (ws[i]) r = step16(r, ws[i]);
    return ~r;
  endfunction

  typedef struct {
    logic [15:0] d;
    logic        is_crc;
    logic        done;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] frame_q[$];
  int          sent;
  logic [15:0] cap_hi, cap_lo;

  // Output monitor and protocol checks, sampled on the falling edge
  always @(negedge clk) begin : mon
    exp_t e;
    if (!reset) begin
      chk("init_dv_overlap", {31'd0, crc_init & crc_dv}, 32'd0);
      chk("ready_outside_busy", {31'd0, din_ready & ~busy}, 32'd0);
      chk("crc_d_passthru", {16'd0, crc_d}, {16'd0, din});
      if (dout_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_dout", {16'd0, dout}, 32'hDEAD_BEEF);
        end else begin
          e = exp_q.pop_front();
          chk("dout", {16'd0, dout}, {16'd0, e.d});
          chk("dout_crc", {31'd0, dout_crc}, {31'd0, e.is_crc});
          chk("frame_done", {31'd0, frame_done}, {31'd0, e.done});
          if (dout_crc && !frame_done) cap_hi = dout;
          if (frame_done) cap_lo = dout;
        end
      end else begin
        chk("done_without_valid", {31'd0, frame_done}, 32'd0);
      end
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    frame_q.delete();
    sent = 0;
  endtask

  task automatic send_word(input logic [15:0] w, input logic last, input bit pulse_lo);
    int n;
    logic [31:0] c;
    exp_t e;
    din = w; din_valid = 1'b1; din_last = last;
    n = 0;
    while (!din_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!din_ready) begin
      chk("ready_timeout", 32'd0, 32'd1);
    end else begin
      frame_q.push_back(w);
      e.d = w; e.is_crc = 1'b0; e.done = 1'b0;
      exp_q.push_back(e);
      sent++;
      @(posedge clk); #1;
      if (last || sent == MAXW) begin
        c = crc_sw(frame_q);
        e.d = c[31:16]; e.is_crc = 1'b1; e.done = 1'b0;
        exp_q.push_back(e);
        e.d = c[15:0]; e.done = 1'b1;
        exp_q.push_back(e);
      end
    end
    din_valid = 1'b0; din_last = 1'b0;
    if ((last || sent == MAXW) && pulse_lo) begin
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      chk("start_in_crc_lo_ignored", {31'd0, busy}, 32'd0);
    end
  endtask

  task automatic run_frame(input logic [15:0] ws[$], input int gap, input bit use_last,
                           input bit pulse_lo);
    int n;
    pulse_start();
    for (int i = 0; i < ws.size(); i++) begin
      if (sent == MAXW) begin
        din = ws[i]; din_valid = 1'b1;
        repeat (2) begin
          @(posedge clk); #1;
          chk("ready_after_limit", {31'd0, din_ready}, 32'd0);
        end
        din_valid = 1'b0;
      end else begin
        send_word(ws[i], use_last && (i == ws.size() - 1), pulse_lo);
        repeat (gap) begin @(posedge clk); #1; end
      end
    end
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("frame_drain", exp_q.size(), 32'd0);
    @(posedge clk); #1;
    chk("idle_after_frame", {31'd0, busy}, 32'd0);
  endtask

  logic [15:0] w1[$];
  logic [15:0] w4[$];
  logic [15:0] w10[$];
  logic [31:0] ref_crc, crc_a;

  initial begin
    reset = 1'b1; start = 1'b0; din = 16'h0000; din_valid = 1'b0; din_last = 1'b0;
    cap_hi = 16'h0000; cap_lo = 16'h0000; sent = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dout_valid", {31'd0, dout_valid}, 32'd0);
    chk("rst_dout", {16'd0, dout}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_word_cnt", {28'd0, word_cnt}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    chk("rst_ready", {31'd0, din_ready}, 32'd0);
    chk("rst_gen_ctl", {29'd0, crc_init, crc_calc, crc_dv}, 32'd0);
    reset = 1'b0;

    // Single-word frame against the standard CRC-32 of two zero bytes
    w1 = '{16'h0000};
    run_frame(w1, 0, 1'b1, 1'b0);
    chk("crc_single_zero", {cap_hi, cap_lo}, 32'h41D9_12FF);
    chk("cnt_single", {28'd0, word_cnt}, 32'd1);
    chk("ovf_single", {31'd0, ovf}, 32'd0);
    ref_crc = {cap_hi, cap_lo};

    // Reset in the middle of DATA
    pulse_start();
    send_word(16'h1111, 1'b0, 1'b0);
    send_word(16'h2222, 1'b0, 1'b0);
    send_word(16'h3333, 1'b0, 1'b0);
    @(negedge clk); #1 reset = 1'b1;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_valid", {31'd0, dout_valid}, 32'd0);
    exp_q.delete();
    @(posedge clk); #1 reset = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    chk("midrst_no_crc", {31'd0, dout_valid}, 32'd0);
    run_frame(w1, 0, 1'b1, 1'b0);
    chk("crc_after_reset", {cap_hi, cap_lo}, ref_crc);

    // Gapped frame must give the same CRC as the dense one
    w4 = '{16'h1234, 16'hABCD, 16'hFFFF, 16'h0001};
    run_frame(w4, 0, 1'b1, 1'b0);
    crc_a = {cap_hi, cap_lo};
    run_frame(w4, 2, 1'b1, 1'b0);
    chk("crc_gapped_eq", {cap_hi, cap_lo}, crc_a);
    chk("cnt_gapped", {28'd0, word_cnt}, 32'd4);

    // Overflow at MAX_WORDS without din_last
    w10.delete();
    for (int i = 0; i < 10; i++) w10.push_back(16'(($urandom & 32'h0000_FFFF) ^ i));
    run_frame(w10, 0, 1'b0, 1'b0);
    chk("ovf_set", {31'd0, ovf}, 32'd1);
    chk("cnt_ovf", {28'd0, word_cnt}, 32'd8);
    chk("ready_idle", {31'd0, din_ready}, 32'd0);

    // Back-to-back: start during CRC_LO ignored, next frame clears ovf
    run_frame(w4, 0, 1'b1, 1'b1);
    chk("ovf_cleared", {31'd0, ovf}, 32'd0);
    chk("crc_b2b_first", {cap_hi, cap_lo}, crc_a);
    for (int i = 0; i < 3; i++) w4[i] = 16'($urandom);
    run_frame(w4, 1, 1'b1, 1'b0);
    chk("cnt_b2b", {28'd0, word_cnt}, 32'd4);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks_r, errors_r);
    $finish;
  end

endmodule
